// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: initiator side of the MEM-stage data memory interface.
// Converts byte addresses to word indices, drives the read/write strobes
// over WAIT_CYCLES+1 access cycles and freezes the pipeline via `ready`.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   MEM_r_en, MEM_w_en    load / store request from the MEM stage
//   address, data_in      byte address and store value
//   ready                 0 = freeze pipeline (combinational)
//   data_out              registered load result toward WB
//   addr_fault            one-cycle pulse after a rejected request
//   mem_r_en, mem_w_en    memory strobes
//   mem_addr, mem_wdata   word index and latched store value
//   mem_rdata             combinational read data from memory
//   load_count, store_count  completed-access counters (MEM_STAGE_STATS_EN only)
//
// Optional feature macro: MEM_STAGE_STATS_EN.

module mem_stage_ctrl #(
   parameter int unsigned WAIT_CYCLES = 4,
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned DEPTH_WORDS = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           MEM_r_en,
   input  logic                           MEM_w_en,
   input  logic [31:0]                    address,
   input  logic [31:0]                    data_in,
   output logic                           ready,
   output logic [31:0]                    data_out,
   output logic                           addr_fault,
   output logic                           mem_r_en,
   output logic                           mem_w_en,
   output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr,
   output logic [31:0]                    mem_wdata,
   input  logic [31:0]                    mem_rdata
`ifdef MEM_STAGE_STATS_EN
   ,
   output logic [15:0]                    load_count,
   output logic [15:0]                    store_count
`endif
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [31:0] ADDR_LO  = 32'(BASE_ADDR);
   localparam logic [31:0] ADDR_HI  = 32'(BASE_ADDR + 4 * DEPTH_WORDS);
   localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);
   localparam logic [CW-1:0] CNT_PRE  = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam bit NO_WAIT = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_is_store;

   logic            w_req;
   logic            w_valid;
   logic [AW-1:0]   w_index;
   logic            w_last;
   logic            w_pre_last;

   // Request qualification: in range and word aligned.
   assign w_req      = MEM_r_en | MEM_w_en;
   assign w_valid    = w_req && (address >= ADDR_LO) && (address < ADDR_HI)
                       && (address[1:0] == 2'b00);
   assign w_index    = AW'((address - ADDR_LO) >> 2);
   assign w_last     = (r_cnt == CNT_LAST);
   // The write strobe is registered, so it is raised one cycle ahead of the final cycle.
   assign w_pre_last = !NO_WAIT && (r_cnt == CNT_PRE);

   // Stall while a valid request waits in IDLE and for the whole ACCESS phase.
   always_comb begin
      ready = 1'b0;
      case (r_state)
         S_IDLE:  ready = !w_valid;
         S_DONE:  ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   // Access sequencer with registered strobes and load capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_is_store <= 1'b0;
         data_out   <= '0;
         addr_fault <= 1'b0;
         mem_r_en   <= 1'b0;
         mem_w_en   <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
`ifdef MEM_STAGE_STATS_EN
         load_count  <= '0;
         store_count <= '0;
`endif
      end else begin
         addr_fault <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_valid) begin
                  // Store wins over a simultaneous load.
                  r_is_store <= MEM_w_en;
                  mem_addr   <= w_index;
                  mem_wdata  <= data_in;
                  r_cnt      <= '0;
                  mem_r_en   <= !MEM_w_en;
                  mem_w_en   <= MEM_w_en && NO_WAIT;
                  r_state    <= S_ACCESS;
               end else if (w_req) begin
                  addr_fault <= 1'b1;
               end
            end
            S_ACCESS: begin
               if (w_last) begin
                  mem_r_en <= 1'b0;
                  mem_w_en <= 1'b0;
                  if (!r_is_store) begin
                     data_out <= mem_rdata;
                  end
`ifdef MEM_STAGE_STATS_EN
                  if (r_is_store) begin
                     store_count <= store_count + 16'd1;
                  end else begin
                     load_count <= load_count + 16'd1;
                  end
`endif
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
                  if (r_is_store && w_pre_last) begin
                     mem_w_en <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               // The old request is still present here; it is not re-issued.
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed testbench for mem_stage_ctrl: instance A uses WAIT_CYCLES=4,
// instance B uses WAIT_CYCLES=0; each has a 64-word memory model.
module tb_mem_stage_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int errors;
   logic mem_init;

   // Instance A (WAIT_CYCLES=4)
   logic        rst_a, a_r, a_w, a_ready, a_fault, a_mr, a_mw;
   logic [31:0] a_addr, a_din, a_dout, a_wd, a_rd;
   logic [5:0]  a_ma;
   // Instance B (WAIT_CYCLES=0)
   logic        rst_b, b_r, b_w, b_ready, b_fault, b_mr, b_mw;
   logic [31:0] b_addr, b_din, b_dout, b_wd, b_rd;
   logic [5:0]  b_ma;
`ifdef MEM_STAGE_STATS_EN
   logic [15:0] a_lc, a_sc, b_lc, b_sc;
`endif

   mem_stage_ctrl #(.WAIT_CYCLES(4), .BASE_ADDR(1024), .DEPTH_WORDS(64)) dut_a (
      .clk(clk), .rst(rst_a), .MEM_r_en(a_r), .MEM_w_en(a_w), .address(a_addr),
      .data_in(a_din), .ready(a_ready), .data_out(a_dout), .addr_fault(a_fault),
      .mem_r_en(a_mr), .mem_w_en(a_mw), .mem_addr(a_ma), .mem_wdata(a_wd),
      .mem_rdata(a_rd)
`ifdef MEM_STAGE_STATS_EN
      , .load_count(a_lc), .store_count(a_sc)
`endif
   );

   mem_stage_ctrl #(.WAIT_CYCLES(0), .BASE_ADDR(1024), .DEPTH_WORDS(64)) dut_b (
      .clk(clk), .rst(rst_b), .MEM_r_en(b_r), .MEM_w_en(b_w), .address(b_addr),
      .data_in(b_din), .ready(b_ready), .data_out(b_dout), .addr_fault(b_fault),
      .mem_r_en(b_mr), .mem_w_en(b_mw), .mem_addr(b_ma), .mem_wdata(b_wd),
      .mem_rdata(b_rd)
`ifdef MEM_STAGE_STATS_EN
      , .load_count(b_lc), .store_count(b_sc)
`endif
   );

   // Memory models with strobe monitors; word i is preset to 0xA5A5_0000 | i.
   logic [31:0] mem_a [64];
   logic [31:0] mem_b [64];
   int          a_wcnt, a_rcnt, b_wcnt, b_rcnt;
   logic [5:0]  a_lwa, b_lwa;
   logic [31:0] a_lwd, b_lwd;

   assign a_rd = mem_a[a_ma];
   assign b_rd = mem_b[b_ma];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem_a[i] <= 32'hA5A5_0000 | 32'(i);
         a_wcnt <= 0; a_rcnt <= 0; a_lwa <= '0; a_lwd <= '0;
      end else begin
         if (a_mw) begin
            mem_a[a_ma] <= a_wd; a_wcnt <= a_wcnt + 1; a_lwa <= a_ma; a_lwd <= a_wd;
         end
         if (a_mr) a_rcnt <= a_rcnt + 1;
      end
   end

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem_b[i] <= 32'hA5A5_0000 | 32'(i);
         b_wcnt <= 0; b_rcnt <= 0; b_lwa <= '0; b_lwd <= '0;
      end else begin
         if (b_mw) begin
            mem_b[b_ma] <= b_wd; b_wcnt <= b_wcnt + 1; b_lwa <= b_ma; b_lwd <= b_wd;
         end
         if (b_mr) b_rcnt <= b_rcnt + 1;
      end
   end

   // Present a request on A at a negedge and wait until ready returns (DONE cycle).
   task automatic run_a(input logic r, input logic w, input logic [31:0] addr,
                        input logic [31:0] din, output int low);
      a_r = r; a_w = w; a_addr = addr; a_din = din; low = 0;
      #1;
      while (a_ready !== 1'b1 && low < 40) begin
         low++;
         @(negedge clk); #1;
      end
      checks++;
      if (low >= 40) begin
         errors++;
         $display("FAIL timeout_a: ready low for %0d cycles, required <= 6", low);
      end
   endtask

   task automatic run_b(input logic r, input logic w, input logic [31:0] addr,
                        input logic [31:0] din, output int low);
      b_r = r; b_w = w; b_addr = addr; b_din = din; low = 0;
      #1;
      while (b_ready !== 1'b1 && low < 40) begin
         low++;
         @(negedge clk); #1;
      end
      checks++;
      if (low >= 40) begin
         errors++;
         $display("FAIL timeout_b: ready low for %0d cycles, required <= 2", low);
      end
   endtask

   task automatic next_a();
      @(negedge clk); a_r = 1'b0; a_w = 1'b0;
   endtask

   task automatic next_b();
      @(negedge clk); b_r = 1'b0; b_w = 1'b0;
   endtask

   task automatic test_reset();
      mem_init = 1'b1; rst_a = 1'b1; rst_b = 1'b1;
      a_r = 0; a_w = 0; a_addr = '0; a_din = '0;
      b_r = 0; b_w = 0; b_addr = '0; b_din = '0;
      repeat (3) @(negedge clk);
      mem_init = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
      #1;
      checks++;
      if ({a_ready, a_fault, a_mr, a_mw} !== 4'b1000) begin
         errors++; $display("FAIL reset_a_ctrl: got %b, required 1000", {a_ready, a_fault, a_mr, a_mw});
      end
      checks++;
      if ({a_dout, a_wd, a_ma} !== 70'd0) begin
         errors++; $display("FAIL reset_a_data: dout=%h wdata=%h addr=%0d, required all 0", a_dout, a_wd, a_ma);
      end
      checks++;
      if ({b_ready, b_fault, b_mr, b_mw, b_dout, b_ma} !== {4'b1000, 38'd0}) begin
         errors++; $display("FAIL reset_b: ready=%b fault=%b dout=%h addr=%0d, required 1/0/0/0", b_ready, b_fault, b_dout, b_ma);
      end
   endtask

   task automatic test_store_load();
      int low, w0, r0;
      @(negedge clk);
      w0 = a_wcnt; r0 = a_rcnt;
      run_a(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, low);
      checks++;
      if (low !== 6) begin errors++; $display("FAIL store_ready_low: got %0d, required 6", low); end
      checks++;
      if (a_wcnt - w0 !== 1 || a_rcnt - r0 !== 0) begin
         errors++; $display("FAIL store_strobes: writes=%0d reads=%0d, required 1/0", a_wcnt - w0, a_rcnt - r0);
      end
      checks++;
      if (a_lwa !== 6'd1 || a_lwd !== 32'hDEADBEEF) begin
         errors++; $display("FAIL store_write: addr=%0d data=%h, required 1/deadbeef", a_lwa, a_lwd);
      end
      checks++;
      if (a_dout !== 32'd0) begin errors++; $display("FAIL store_dout: got %h, required 0", a_dout); end
      next_a();
      w0 = a_wcnt; r0 = a_rcnt;
      run_a(1'b1, 1'b0, 32'd1028, 32'd0, low);
      checks++;
      if (low !== 6) begin errors++; $display("FAIL load_ready_low: got %0d, required 6", low); end
      checks++;
      if (a_dout !== 32'hDEADBEEF) begin errors++; $display("FAIL load_dout: got %h, required deadbeef", a_dout); end
      checks++;
      if (a_rcnt - r0 !== 5 || a_wcnt - w0 !== 0) begin
         errors++; $display("FAIL load_strobes: reads=%0d writes=%0d, required 5/0", a_rcnt - r0, a_wcnt - w0);
      end
      next_a();
   endtask

   task automatic test_boundaries();
      int low, w0;
      @(negedge clk);
      run_b(1'b1, 1'b0, 32'd1276, 32'd0, low);
      checks++;
      if (low !== 2 || b_ma !== 6'd63 || b_dout !== 32'hA5A5_003F) begin
         errors++; $display("FAIL bound_load_top: low=%0d addr=%0d dout=%h, required 2/63/a5a5003f", low, b_ma, b_dout);
      end
      next_b();
      run_b(1'b1, 1'b0, 32'd1024, 32'd0, low);
      checks++;
      if (low !== 2 || b_ma !== 6'd0 || b_dout !== 32'hA5A5_0000) begin
         errors++; $display("FAIL bound_load_bot: low=%0d addr=%0d dout=%h, required 2/0/a5a50000", low, b_ma, b_dout);
      end
      next_b();
      w0 = b_wcnt;
      run_b(1'b0, 1'b1, 32'd1276, 32'hCAFEF00D, low);
      checks++;
      if (low !== 2 || b_wcnt - w0 !== 1 || b_lwa !== 6'd63 || b_lwd !== 32'hCAFEF00D) begin
         errors++; $display("FAIL bound_store_top: low=%0d writes=%0d addr=%0d data=%h, required 2/1/63/cafef00d",
                            low, b_wcnt - w0, b_lwa, b_lwd);
      end
      next_b();
      run_b(1'b1, 1'b0, 32'd1276, 32'd0, low);
      checks++;
      if (b_dout !== 32'hCAFEF00D) begin errors++; $display("FAIL bound_reload: got %h, required cafef00d", b_dout); end
      next_b();
   endtask

   task automatic test_faults();
      logic [31:0] fa [3];
      logic [31:0] d0;
      int w0, r0;
      fa[0] = 32'd1020; fa[1] = 32'd1280; fa[2] = 32'd1026;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         d0 = a_dout; w0 = a_wcnt; r0 = a_rcnt;
         a_addr = fa[k]; a_din = 32'h0BAD_0BAD;
         a_r = (k != 2); a_w = (k == 2);
         #1;
         checks++;
         if (a_ready !== 1'b1) begin errors++; $display("FAIL fault_ready[%0d]: got %b, required 1", k, a_ready); end
         @(negedge clk);
         a_r = 1'b0; a_w = 1'b0;
         #1;
         checks++;
         if (a_fault !== 1'b1) begin errors++; $display("FAIL fault_pulse[%0d]: got %b, required 1", k, a_fault); end
         @(negedge clk); #1;
         checks++;
         if (a_fault !== 1'b0 || a_wcnt != w0 || a_rcnt != r0 || a_dout !== d0) begin
            errors++; $display("FAIL fault_after[%0d]: fault=%b writes=%0d reads=%0d dout=%h, required 0/0/0/%h",
                               k, a_fault, a_wcnt - w0, a_rcnt - r0, a_dout, d0);
         end
      end
   endtask

   task automatic test_simultaneous();
      int low, w0, r0;
      logic [31:0] d0;
      @(negedge clk);
      d0 = a_dout; w0 = a_wcnt; r0 = a_rcnt;
      run_a(1'b1, 1'b1, 32'd1032, 32'h5, low);
      checks++;
      if (low !== 6 || a_wcnt - w0 !== 1 || a_rcnt - r0 !== 0) begin
         errors++; $display("FAIL simul_strobes: low=%0d writes=%0d reads=%0d, required 6/1/0", low, a_wcnt - w0, a_rcnt - r0);
      end
      checks++;
      if (a_lwa !== 6'd2 || a_lwd !== 32'h5 || a_dout !== d0) begin
         errors++; $display("FAIL simul_write: addr=%0d data=%h dout=%h, required 2/5/%h", a_lwa, a_lwd, a_dout, d0);
      end
      next_a();
   endtask

   task automatic test_reset_access();
      int w0;
      @(negedge clk);
      w0 = a_wcnt;
      a_w = 1'b1; a_addr = 32'd1036; a_din = 32'h1234;
      @(negedge clk);             // first ACCESS cycle
      @(negedge clk);             // second ACCESS cycle
      rst_a = 1'b1; a_w = 1'b0;
      @(negedge clk);
      rst_a = 1'b0;
      #1;
      checks++;
      if (a_ready !== 1'b1 || a_mw !== 1'b0 || a_mr !== 1'b0 || a_dout !== 32'd0) begin
         errors++; $display("FAIL rst_access_state: ready=%b mw=%b mr=%b dout=%h, required 1/0/0/0", a_ready, a_mw, a_mr, a_dout);
      end
      repeat (8) @(negedge clk);
      checks++;
      if (a_wcnt != w0 || mem_a[3] !== 32'hA5A5_0003) begin
         errors++; $display("FAIL rst_access_nowrite: writes=%0d mem[3]=%h, required 0/a5a50003", a_wcnt - w0, mem_a[3]);
      end
   endtask

   task automatic test_back_to_back();
      int low, w0, r0;
      @(negedge clk);
      w0 = a_wcnt; r0 = a_rcnt;
      run_a(1'b1, 1'b0, 32'd1024, 32'd0, low);
      checks++;
      if (low !== 6 || a_dout !== 32'hA5A5_0000) begin
         errors++; $display("FAIL b2b_load: low=%0d dout=%h, required 6/a5a50000", low, a_dout);
      end
      @(negedge clk);
      run_a(1'b0, 1'b1, 32'd1028, 32'h77, low);
      checks++;
      if (low !== 6 || a_wcnt - w0 !== 1 || a_lwa !== 6'd1 || a_lwd !== 32'h77) begin
         errors++; $display("FAIL b2b_store: low=%0d writes=%0d addr=%0d data=%h, required 6/1/1/77", low, a_wcnt - w0, a_lwa, a_lwd);
      end
      checks++;
      if (a_rcnt - r0 !== 5 || a_dout !== 32'hA5A5_0000) begin
         errors++; $display("FAIL b2b_load_once: reads=%0d dout=%h, required 5/a5a50000", a_rcnt - r0, a_dout);
      end
`ifdef MEM_STAGE_STATS_EN
      checks++;
      if (a_lc !== 16'd1 || a_sc !== 16'd1) begin
         errors++; $display("FAIL b2b_stats: load_count=%0d store_count=%0d, required 1/1", a_lc, a_sc);
      end
`endif
      next_a();
   endtask

   initial begin
      checks = 0; errors = 0;
      test_reset();
      test_store_load();
      test_boundaries();
      test_faults();
      test_simultaneous();
      test_reset_access();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
